sync_fifo_prog: RTL

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and registered read data.
// Optional saturating overflow/underflow event counters when SYNC_FIFO_ERR_CNT_EN is defined.
module sync_fifo_prog #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            wr_en,
  input  logic                            rd_en,
  input  logic                            flush,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
`ifdef SYNC_FIFO_ERR_CNT_EN
  output logic [7:0]                      ovf_cnt,
  output logic [7:0]                      udf_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeCnt    = CntW'(AE_LEVEL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q, wr_ack_q, overflow_q, underflow_q;
  logic                  wr_acc, rd_acc, ovf_evt, udf_evt;

  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AfCnt) && (count_q < DepthCnt);
  assign almostempty = (count_q != '0) && (count_q <= AeCnt);

  // Acceptance uses current-cycle flags, so a full FIFO can still take a read
  // and an empty one a write in the same cycle; the other side is rejected.
  assign wr_acc  = wr_en & ~full  & ~flush;
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign ovf_evt = wr_en &  full  & ~flush;
  assign udf_evt = rd_en &  empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (rd_acc) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (rd_acc) data_out_q <= mem[rd_ptr_q];
      rd_valid_q  <= rd_acc;
      wr_ack_q    <= wr_acc;
      overflow_q  <= ovf_evt;
      underflow_q <= udf_evt;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;

`ifdef SYNC_FIFO_ERR_CNT_EN
  logic [7:0] ovf_cnt_q, udf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else if (flush) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      if (ovf_evt && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      if (udf_evt && udf_cnt_q != 8'hFF) udf_cnt_q <= udf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udf_cnt = udf_cnt_q;
`endif

endmodule
